sram_port_arbiter: RTL
======================

Name: sram_port_arbiter

Overview:
- Shares a single SRAM-like memory port between the core's instruction-fetch requester (IF) and data requester (EX/MEM).
- Sits between the pipeline's inst/data request channels and the external memory port.
- Accepts one transaction at a time from either requester and sequences it through a request/response handshake.
- Gives the data side priority, with a bounded-starvation counter for fetch.
- Reports a stall request to CTRL while any requester is waiting.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- FAIR_LIMIT, 2, maximum consecutive data grants while an inst request is pending; legal range 1..7.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- inst_req  in  1  inst request valid; held with payload until inst_addr_ok.
- inst_addr  in  ADDR_W  inst address.
- inst_addr_ok  out  1  inst request accepted (1-cycle pulse).
- inst_data_ok  out  1  inst response valid (1-cycle pulse).
- inst_rdata  out  DATA_W  inst read data, valid with inst_data_ok.
- data_req  in  1  data request valid; held with payload until data_addr_ok.
- data_wr  in  1  1 = write, 0 = read.
- data_wstrb  in  DATA_W/8  byte write strobes.
- data_addr  in  ADDR_W  data address.
- data_wdata  in  DATA_W  write data.
- data_addr_ok  out  1  data request accepted (1-cycle pulse).
- data_data_ok  out  1  data response / write-complete (1-cycle pulse).
- data_rdata  out  DATA_W  data read data, valid with data_data_ok.
- mem_req  out  1  downstream request valid.
- mem_wr  out  1  downstream write.
- mem_wstrb  out  DATA_W/8  downstream strobes.
- mem_addr  out  ADDR_W  downstream address.
- mem_wdata  out  DATA_W  downstream write data.
- mem_addr_ok  in  1  downstream accepted request.
- mem_data_ok  in  1  downstream response valid.
- mem_rdata  in  DATA_W  downstream read data.
- stallreq_for_mem  out  1  stall request to CTRL.

Behaviour:
- Reset (rst=0, async): state=IDLE; owner=0; fair_cnt=0; latched regs=0; every output 0.
- FSM states: IDLE, REQ, RESP.
- IDLE, no request: stay in IDLE.
- IDLE, request present, grant rule:
  - data only -> grant data.
  - inst only -> grant inst.
  - both -> data, unless fair_cnt==FAIR_LIMIT, in which case inst.
- IDLE, on grant (same cycle):
  - pulse granted x_addr_ok (combinational from IDLE & grant).
  - latch wr/wstrb/addr/wdata into internal regs; inst grant latches wr=0, wstrb=0.
  - owner <= granted side; next state REQ.
- fair_cnt:
  - increments on a data grant while inst_req=1, saturating at FAIR_LIMIT.
  - clears on any inst grant.
  - clears on a data grant with inst_req=0.
- REQ:
  - mem_req=1; mem_* driven from latched regs only (never from requester inputs).
  - mem_addr_ok=1 -> RESP next cycle; otherwise hold REQ with stable payload.
- RESP:
  - mem_req=0; wait for mem_data_ok.
  - On mem_data_ok: pulse owner's x_data_ok; x_rdata = mem_rdata combinationally in the same cycle; next state IDLE.
  - The non-owner's data_ok is never asserted.
- mem_data_ok outside RESP: ignored.
- inst_rdata / data_rdata outside their data_ok pulse: 0.
- Minimum occupancy: 3 cycles per transaction (IDLE grant, REQ with immediate addr_ok, RESP with immediate data_ok). Back-to-back grants are possible from the IDLE following the response.
- Requester rule: inputs sampled only in IDLE. A request dropped before addr_ok is simply not granted. A request arriving during REQ/RESP waits.
- stallreq_for_mem = (inst_req & ~inst_addr_ok) | (data_req & ~data_addr_ok) | (state!=IDLE).
- Reset mid-transaction: the in-flight transaction is abandoned and no x_data_ok is issued. A late mem_data_ok after reset release is ignored because state is IDLE.
- Simultaneous grant and request-drop in the same cycle cannot occur: addr_ok is combinational, and the requester samples it at the edge.

Test Plan:
- Reset: rst=0 with data_req=1 -> all outputs 0, no addr_ok; after release, data_addr_ok pulses in first IDLE cycle.
- Inst read alone: inst_req=1, addr=0xBFC00000; mem_addr_ok=1 immediately; mem_data_ok next cycle with rdata=0x24010001 -> inst_addr_ok at c0, mem_req at c1 with mem_addr=0xBFC00000, mem_wr=0, inst_data_ok + inst_rdata=0x24010001 at c2.
- Data write: data_req=1, wr=1, wstrb=0xF, addr=0x80001000, wdata=0xDEADBEEF; mem_addr_ok delayed 3 cycles -> mem_req held 3 cycles with stable payload; data_data_ok exactly once; stallreq_for_mem high throughout.
- Contention, FAIR_LIMIT=2: both reqs continuously asserted -> grant order data, data, inst, data, data, inst; inst_data_ok never seen by data side.
- Reset mid-RESP: assert rst=0 while in RESP, then mem_data_ok=1 after release -> no data_ok pulse, state IDLE, next request granted normally.
- Slow memory: mem_data_ok delayed 5 cycles -> no new addr_ok to either side until the response completes; stallreq_for_mem=1 every cycle.

Source files
------------

// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_port_arbiter
// Description : Shares one SRAM-like memory port between the instruction-fetch
//               and data requesters. One transaction in flight at a time; the
//               data side wins contention except when fetch has been passed
//               over FAIR_LIMIT times in a row.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FAIR_LIMIT = 2
) (
  input  logic                clk,
  input  logic                rst,
  // instruction requester
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  // data requester
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  // downstream memory port
  output logic                mem_req,
  output logic                mem_wr,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata,
  // pipeline control
  output logic                stallreq_for_mem
);

  localparam int         c_STRB_W   = DATA_W / 8;
  localparam logic [2:0] c_FAIR_MAX = 3'(FAIR_LIMIT);
  localparam logic       c_OWN_INST = 1'b0;
  localparam logic       c_OWN_DATA = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic                 r_owner;
  logic [2:0]           r_fair_cnt;
  logic                 r_wr;
  logic [c_STRB_W-1:0]  r_wstrb;
  logic [ADDR_W-1:0]    r_addr;
  logic [DATA_W-1:0]    r_wdata;

  logic w_idle;
  logic w_fair_hit;
  logic w_grant_data;
  logic w_grant_inst;

  // Grant decision is only meaningful in IDLE; fetch wins a tie once starved.
  assign w_idle       = (r_state == ST_IDLE);
  assign w_fair_hit   = (r_fair_cnt == c_FAIR_MAX);
  assign w_grant_data = w_idle & data_req & ~(inst_req & w_fair_hit);
  assign w_grant_inst = w_idle & inst_req & ~w_grant_data;

  // Next-state and all handshake/memory outputs; everything defaults to idle/0.
  always_comb begin
    w_state_next = r_state;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    inst_rdata   = '0;
    data_rdata   = '0;
    mem_req      = 1'b0;
    mem_wr       = 1'b0;
    mem_wstrb    = '0;
    mem_addr     = '0;
    mem_wdata    = '0;
    case (r_state)
      ST_IDLE: begin
        // While reset is held the state is already IDLE, so gate acceptance
        // explicitly to keep every output quiet.
        inst_addr_ok = w_grant_inst & rst;
        data_addr_ok = w_grant_data & rst;
        if (w_grant_inst | w_grant_data) begin
          w_state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        // Payload comes only from the latched copy so it stays stable while
        // the memory stalls, whatever the requesters do meanwhile.
        mem_req   = 1'b1;
        mem_wr    = r_wr;
        mem_wstrb = r_wstrb;
        mem_addr  = r_addr;
        mem_wdata = r_wdata;
        if (mem_addr_ok) begin
          w_state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if (mem_data_ok) begin
          w_state_next = ST_IDLE;
          if (r_owner == c_OWN_DATA) begin
            data_data_ok = 1'b1;
            data_rdata   = mem_rdata;
          end else begin
            inst_data_ok = 1'b1;
            inst_rdata   = mem_rdata;
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Stall while anyone is waiting for acceptance or a transaction is in flight.
  assign stallreq_for_mem = rst & ((inst_req & ~inst_addr_ok) |
                                   (data_req & ~data_addr_ok) |
                                   ~w_idle);

  // State register, ownership, request latch and fetch-starvation counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_owner    <= c_OWN_INST;
      r_fair_cnt <= 3'd0;
      r_wr       <= 1'b0;
      r_wstrb    <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_grant_data) begin
        r_owner <= c_OWN_DATA;
        r_wr    <= data_wr;
        r_wstrb <= data_wstrb;
        r_addr  <= data_addr;
        r_wdata <= data_wdata;
        // Count only grants that bypassed a waiting fetch.
        if (inst_req) begin
          r_fair_cnt <= w_fair_hit ? r_fair_cnt : r_fair_cnt + 3'd1;
        end else begin
          r_fair_cnt <= 3'd0;
        end
      end else if (w_grant_inst) begin
        r_owner    <= c_OWN_INST;
        r_wr       <= 1'b0;
        r_wstrb    <= '0;
        r_addr     <= inst_addr;
        r_wdata    <= '0;
        r_fair_cnt <= 3'd0;
      end
    end
  end

endmodule
`default_nettype wire
